// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default VGA timing, frame totals, coordinate type and update FSM states
package vga_pkg;

  localparam int H_DISP_DEF = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_DISP_DEF = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  function automatic int line_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = line_total(H_DISP_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = line_total(V_DISP_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef logic [10:0] coord_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } upd_state_e;

  function automatic logic [15:0] rotl1(input logic [15:0] val);
    return {val[14:0], val[15]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - h/v counters with registered sync, enable and coordinate decode
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISP = H_DISP_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_DISP = V_DISP_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic   vga_clk,
  input  logic   vga_rst_n,
  output logic   hsync,
  output logic   vsync,
  output logic   disp_en,
  output coord_t pixel_xpos,
  output coord_t pixel_ypos,
  output logic   frame_start,
  output logic   last_pixel
);

  localparam int     H_TOTAL = line_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int     V_TOTAL = line_total(V_DISP, V_FP, V_SYNC, V_BP);
  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS   = coord_t'(H_DISP);
  localparam coord_t V_VIS   = coord_t'(V_DISP);
  localparam coord_t HS_BEG  = coord_t'(H_DISP + H_FP);
  localparam coord_t HS_END  = coord_t'(H_DISP + H_FP + H_SYNC);
  localparam coord_t VS_BEG  = coord_t'(V_DISP + V_FP);
  localparam coord_t VS_END  = coord_t'(V_DISP + V_FP + V_SYNC);

  coord_t h_q, h_d, v_q, v_d;
  coord_t xpos_q, xpos_d, ypos_q, ypos_d;
  logic   hsync_q, hsync_d, vsync_q, vsync_d;
  logic   disp_q, disp_d, fs_q, fs_d;
  logic   h_end, v_end;

  // Outputs decode the current counter state, so they all trail the counters by one cycle together.
  always_comb begin
    h_end      = (h_q == H_LAST);
    v_end      = (v_q == V_LAST);
    last_pixel = h_end && v_end;
    h_d        = h_end ? '0 : h_q + 11'd1;
    v_d        = v_q;
    if (h_end) begin
      v_d = v_end ? '0 : v_q + 11'd1;
    end
    disp_d  = (h_q < H_VIS) && (v_q < V_VIS);
    hsync_d = !((h_q >= HS_BEG) && (h_q < HS_END));
    vsync_d = !((v_q >= VS_BEG) && (v_q < VS_END));
    xpos_d  = disp_d ? h_q : '0;
    ypos_d  = disp_d ? v_q : '0;
    fs_d    = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (!vga_rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      disp_q  <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      disp_q  <= disp_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign disp_en     = disp_q;
  assign pixel_xpos  = xpos_q;
  assign pixel_ypos  = ypos_q;
  assign frame_start = fs_q;

endmodule

// File: rtl/vga_frame_ctrl.sv
// rtl/vga_frame_ctrl.sv - VGA timing plus frame-synchronous LED pattern update handshake
// Optional walking-one test pattern on tp_sel when VGA_TEST_PATTERN_EN is defined.
module vga_frame_ctrl
  import vga_pkg::*;
#(
  parameter int H_DISP = H_DISP_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_DISP = V_DISP_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic        vga_clk,
  input  logic        vga_rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        tp_sel,
`endif
  input  logic [15:0] led_in,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic        hsync,
  output logic        vsync,
  output logic        disp_en,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [15:0] led_frame,
  output logic        frame_start
);

  logic last_pixel;

  vga_timing_gen #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .vga_clk    (vga_clk),
    .vga_rst_n  (vga_rst_n),
    .hsync      (hsync),
    .vsync      (vsync),
    .disp_en    (disp_en),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .frame_start(frame_start),
    .last_pixel (last_pixel)
  );

  upd_state_e  state_q, state_d;
  logic        armed_q, armed_d;
  logic        ack_q, ack_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] led_q, led_d;
  logic        capture, commit;
`ifdef VGA_TEST_PATTERN_EN
  logic [15:0] walk_q, walk_d;
`endif

  // A capture on the commit cycle still commits the old pend_q; the new value waits in PEND.
  always_comb begin
    capture = upd_req && armed_q;
    commit  = (state_q == ST_PEND) && last_pixel;
    ack_d   = capture;
    armed_d = armed_q;
    if (!upd_req) begin
      armed_d = 1'b1;
    end else if (capture) begin
      armed_d = 1'b0;
    end
    pend_d  = capture ? led_in : pend_q;
    state_d = state_q;
    if (capture) begin
      state_d = ST_PEND;
    end else if (commit) begin
      state_d = ST_IDLE;
    end
    led_d = commit ? pend_q : led_q;
`ifdef VGA_TEST_PATTERN_EN
    walk_d = walk_q;
    if (!tp_sel) begin
      walk_d = '0;
    end else if (last_pixel) begin
      walk_d = (walk_q == '0) ? 16'h0001 : rotl1(walk_q);
      led_d  = walk_d;
    end
`endif
  end

  always_ff @(posedge vga_clk) begin
    if (!vga_rst_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
      pend_q  <= '0;
      led_q   <= '0;
`ifdef VGA_TEST_PATTERN_EN
      walk_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
`ifdef VGA_TEST_PATTERN_EN
      walk_q  <= walk_d;
`endif
    end
  end

  assign upd_ack   = ack_q;
  assign led_frame = led_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// tb/tb_vga_frame_ctrl.sv - self-checking bench for vga_frame_ctrl on a reduced frame geometry
module tb_vga_frame_ctrl;

  localparam int HD = 16, HF = 2, HS = 4, HB = 3;
  localparam int VD = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_req = 1'b0;
  logic [15:0] led_in = '0;
  logic        upd_ack, hsync, vsync, disp_en, frame_start;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic [15:0] led_frame;

  always #5 clk = ~clk;

  vga_frame_ctrl #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .vga_clk    (clk),
    .vga_rst_n  (rst_n),
    .led_in     (led_in),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .hsync      (hsync),
    .vsync      (vsync),
    .disp_en    (disp_en),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .led_frame  (led_frame),
    .frame_start(frame_start)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: m_n counts clock edges since reset; a request is taken on its first high cycle,
  // and the newest value taken before a frame's final pixel edge is what that edge shows.
  int          m_n = 0;
  logic        m_prev_req = 1'b0;
  logic [15:0] m_led = '0;
  logic        m_ack = 1'b0;
  logic [15:0] m_pend[$];
  int          ack_seen = 0;
  bit          seen_1111 = 1'b0;

  function automatic logic [25:0] exp_timing(input int n);
    int idx, h, v;
    logic de;
    if (n == 0) return {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0};
    idx = (n - 1) % FR;
    h   = idx % HT;
    v   = idx / HT;
    de  = (h < HD) && (v < VD);
    return {!(h >= HD + HF && h < HD + HF + HS), !(v >= VD + VF && v < VD + VF + VS), de,
            de ? 11'(h) : 11'd0, de ? 11'(v) : 11'd0, (idx == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_n = 0; m_prev_req = 1'b0; m_pend.delete(); m_led = '0; m_ack = 1'b0;
    end else begin
      if ((m_n % FR) == FR - 1 && m_pend.size() > 0) begin
        m_led = m_pend[$];
        m_pend.delete();
      end
      m_ack = upd_req && !m_prev_req;
      if (m_ack) m_pend.push_back(led_in);
      m_prev_req = upd_req;
      m_n++;
    end
    #1;
    if (upd_ack === 1'b1) ack_seen++;
    if (led_frame === 16'h1111) seen_1111 = 1'b1;
  endtask

  task automatic wait_to(input int target);
    int guard = 0;
    while ((m_n % FR) != target && guard < 2 * FR) begin
      tick();
      guard++;
    end
    n_cmp++;
    if ((m_n % FR) != target) begin
      n_bad++;
      $display("FAIL wait_to timeout: at %0d, want %0d", m_n % FR, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; upd_req = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start} !== exp_timing(0)) begin
      n_bad++;
      $display("FAIL reset_timing: got %h want %h",
               {hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start}, exp_timing(0));
    end
    n_cmp++;
    if (led_frame !== 16'h0000) begin
      n_bad++; $display("FAIL reset_led: got %h want 0000", led_frame);
    end
    n_cmp++;
    if (upd_ack !== 1'b0) begin
      n_bad++; $display("FAIL reset_ack: got %b want 0", upd_ack);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int hs_low = 0, vs_low = 0, de_cnt = 0, fs_cnt = 0, last_fs = -1, bad_gap = 0;
    logic [25:0] exp;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      exp = exp_timing(m_n);
      n_cmp++;
      if ({hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start} !== exp) begin
        n_bad++;
        $display("FAIL timing_n%0d: got %h want %h", m_n,
                 {hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start}, exp);
      end
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (disp_en) de_cnt++;
      if (frame_start) begin
        fs_cnt++;
        if (last_fs >= 0 && m_n - last_fs != FR) bad_gap++;
        last_fs = m_n;
      end
    end
    n_cmp++;
    if (fs_cnt != 2 || bad_gap != 0) begin
      n_bad++; $display("FAIL frame_start: count %0d gaps_bad %0d, want 2 and 0", fs_cnt, bad_gap);
    end
    n_cmp++;
    if (hs_low != 2 * HS * VT) begin
      n_bad++; $display("FAIL hsync_low: got %0d want %0d", hs_low, 2 * HS * VT);
    end
    n_cmp++;
    if (vs_low != 2 * VS * HT) begin
      n_bad++; $display("FAIL vsync_low: got %0d want %0d", vs_low, 2 * VS * HT);
    end
    n_cmp++;
    if (de_cnt != 2 * HD * VD) begin
      n_bad++; $display("FAIL disp_en_count: got %0d want %0d", de_cnt, 2 * HD * VD);
    end
  endtask

  task automatic test_single_update();
    wait_to(FR / 2);
    upd_req = 1'b1; led_in = 16'hF00F;
    tick();
    n_cmp++;
    if (upd_ack !== 1'b1) begin n_bad++; $display("FAIL single_ack: got %b want 1", upd_ack); end
    upd_req = 1'b0;
    tick();
    n_cmp++;
    if (upd_ack !== 1'b0) begin n_bad++; $display("FAIL single_ack_width: got %b want 0", upd_ack); end
    wait_to(FR - 1);
    n_cmp++;
    if (led_frame !== 16'h0000) begin
      n_bad++; $display("FAIL single_hold: got %h want 0000", led_frame);
    end
    tick();
    n_cmp++;
    if (led_frame !== 16'hF00F) begin
      n_bad++; $display("FAIL single_commit: got %h want f00f", led_frame);
    end
  endtask

  task automatic test_two_updates();
    int ack0 = ack_seen;
    seen_1111 = 1'b0;
    wait_to(30);
    upd_req = 1'b1; led_in = 16'h1111; tick();
    upd_req = 1'b0; repeat (3) tick();
    upd_req = 1'b1; led_in = 16'h2222; tick();
    upd_req = 1'b0; tick();
    n_cmp++;
    if (ack_seen - ack0 != 2) begin
      n_bad++; $display("FAIL two_acks: got %0d want 2", ack_seen - ack0);
    end
    wait_to(FR - 1);
    n_cmp++;
    if (led_frame !== 16'hF00F) begin n_bad++; $display("FAIL two_hold: got %h want f00f", led_frame); end
    tick();
    n_cmp++;
    if (led_frame !== 16'h2222) begin n_bad++; $display("FAIL two_commit: got %h want 2222", led_frame); end
    n_cmp++;
    if (seen_1111) begin n_bad++; $display("FAIL two_no_1111: 1111 observed, want never"); end
  endtask

  task automatic test_hold();
    int ack0 = ack_seen;
    logic [15:0] val = 16'($urandom);
    upd_req = 1'b1; led_in = val;
    repeat (3 * FR) tick();
    n_cmp++;
    if (ack_seen - ack0 != 1) begin
      n_bad++; $display("FAIL hold_acks: got %0d want 1", ack_seen - ack0);
    end
    n_cmp++;
    if (led_frame !== val) begin n_bad++; $display("FAIL hold_value: got %h want %h", led_frame, val); end
    upd_req = 1'b0;
    tick();
  endtask

  task automatic test_boundary_capture();
    logic [15:0] nv = 16'($urandom) | 16'h8000;
    wait_to(40);
    upd_req = 1'b1; led_in = 16'h00FF; tick();
    upd_req = 1'b0; tick();
    wait_to(FR - 1);
    upd_req = 1'b1; led_in = nv;
    tick();
    n_cmp++;
    if (upd_ack !== 1'b1) begin n_bad++; $display("FAIL bnd_ack: got %b want 1", upd_ack); end
    n_cmp++;
    if (led_frame !== 16'h00FF) begin n_bad++; $display("FAIL bnd_commit_old: got %h want 00ff", led_frame); end
    upd_req = 1'b0;
    tick();
    wait_to(FR - 1);
    n_cmp++;
    if (led_frame !== 16'h00FF) begin n_bad++; $display("FAIL bnd_hold: got %h want 00ff", led_frame); end
    tick();
    n_cmp++;
    if (led_frame !== nv) begin n_bad++; $display("FAIL bnd_commit_new: got %h want %h", led_frame, nv); end
  endtask

  task automatic test_mid_reset();
    wait_to(5);
    upd_req = 1'b1; led_in = 16'hABCD; tick();
    upd_req = 1'b0; tick();
    wait_to(6 * HT + 10);
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start, upd_ack, led_frame} !==
        {exp_timing(0), 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %h want %h",
               {hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start, upd_ack, led_frame},
               {exp_timing(0), 1'b0, 16'h0000});
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start} !== exp_timing(1)) begin
      n_bad++;
      $display("FAIL midrst_first: got %h want %h",
               {hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start}, exp_timing(1));
    end
    repeat (FR + 5) tick();
    n_cmp++;
    if (led_frame !== 16'h0000) begin n_bad++; $display("FAIL midrst_discard: got %h want 0000", led_frame); end
  endtask

  task automatic test_random();
    logic [25:0] exp;
    for (int i = 0; i < 3 * FR; i++) begin
      if ($urandom_range(0, 7) == 0) upd_req = ~upd_req;
      if (!upd_req) led_in = 16'($urandom);
      tick();
      exp = exp_timing(m_n);
      n_cmp++;
      if ({hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start, upd_ack, led_frame} !==
          {exp, m_ack, m_led}) begin
        n_bad++;
        $display("FAIL random_n%0d: got %h want %h", m_n,
                 {hsync, vsync, disp_en, pixel_xpos, pixel_ypos, frame_start, upd_ack, led_frame},
                 {exp, m_ack, m_led});
      end
    end
    upd_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_timing();
    test_single_update();
    test_two_updates();
    test_hold();
    test_boundary_capture();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
